handshake_export_arbiter: RTL and testbench

- Round-robin arbiter that shares one toggle (two-phase) req/ack clock-crossing channel among PORTS local requesters in the source domain.
- Selects one requester and latches its word plus source tag onto the channel data lines.
- Toggles handshake_req and waits for the synchronized handshake_ack to match before serving the next requester.
- The peer is the clock-domain import block in the destination domain; it recovers the source from handshake_tag.

---
 rtl/handshake_export_arbiter.sv | 102 ++++++++++
 tb/tb_handshake_export_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_export_arbiter.sv
// rtl/handshake_export_arbiter.sv - round-robin arbiter sharing one two-phase req/ack crossing channel
module handshake_export_arbiter #(
  parameter int SIZE  = 8,
  parameter int PORTS = 4,
  parameter int TAG_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS*SIZE-1:0] in_data,
  input  logic [PORTS-1:0]      in_valid,
  output logic [PORTS-1:0]      in_ready,
  output logic [SIZE-1:0]       handshake_data,
  output logic [TAG_W-1:0]      handshake_tag,
  output logic                  handshake_req,
  input  logic                  handshake_ack,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(PORTS - 1);

  state_t           state, state_next;
  logic             ack_x, ack_s;
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] cand;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_found;
  logic [SIZE-1:0]  grant_word;
  logic             grant;

  // handshake_ack is only ever observed through this two-flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_x <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_x <= handshake_ack;
      ack_s <= ack_x;
    end
  end

  // Scan last_grant+1, +2, ... with an explicit wrap so PORTS need not be a power of two
  always_comb begin
    cand        = last_grant;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + TAG_W'(1);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_idx == TAG_W'(i)) grant_word = in_data[i*SIZE +: SIZE];
    end
  end

  // No grant while the channel is still unbalanced (e.g. peer left holding ack after our reset)
  always_comb begin
    in_ready = '0;
    if (state == IDLE && grant_found && (ack_s == handshake_req)) in_ready[grant_idx] = 1'b1;
  end

  assign grant = |in_ready;
  assign busy  = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT:    if (ack_s == handshake_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= LAST_IDX;
      handshake_data <= '0;
      handshake_tag  <= '0;
      handshake_req  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        handshake_data <= grant_word;
        handshake_tag  <= grant_idx;
        last_grant     <= grant_idx;
      end
      // Data/tag were loaded one edge earlier, so they are settled before req moves
      if (state == SEND) handshake_req <= ~handshake_req;
    end
  end

endmodule

// File: tb/tb_handshake_export_arbiter.sv
// tb/tb_handshake_export_arbiter.sv - randomized self-checking bench for handshake_export_arbiter
module tb_handshake_export_arbiter;

  localparam int SIZE  = 8;
  localparam int PORTS = 4;
  localparam int TAG_W = 2;

  logic                  clk   = 1'b0;
  logic                  pclk  = 1'b0;
  logic                  rst_n = 1'b0;
  logic [SIZE-1:0]       word [PORTS];
  logic [PORTS*SIZE-1:0] in_data;
  logic [PORTS-1:0]      in_valid;
  logic [PORTS-1:0]      in_ready;
  logic [SIZE-1:0]       handshake_data;
  logic [TAG_W-1:0]      handshake_tag;
  logic                  handshake_req;
  logic                  handshake_ack;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;
  always #13 pclk = ~pclk;

  always_comb begin
    for (int i = 0; i < PORTS; i++) in_data[i*SIZE +: SIZE] = word[i];
  end

  handshake_export_arbiter #(.SIZE(SIZE), .PORTS(PORTS), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .handshake_data (handshake_data),
    .handshake_tag  (handshake_tag),
    .handshake_req  (handshake_req),
    .handshake_ack  (handshake_ack),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [PORTS-1:0] model_pick(input logic [PORTS-1:0] v, input int last);
    logic [PORTS-1:0] r;
    r = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (v[(last + k) % PORTS] && r == '0) r[(last + k) % PORTS] = 1'b1;
    end
    return r;
  endfunction

  // Destination-domain peer: sync req, capture word, ack after a random delay
  logic             peer_rst  = 1'b1;
  logic             peer_ack;
  logic             rq1, rq2, pend;
  int               pcnt;
  int               dly_lo = 0;
  int               dly_hi = 0;
  logic             force_en  = 1'b0;
  logic             force_val = 1'b0;
  logic [SIZE-1:0]  rx_data [$];
  logic [TAG_W-1:0] rx_tag  [$];

  assign handshake_ack = force_en ? force_val : peer_ack;

  always @(posedge pclk or posedge peer_rst) begin
    if (peer_rst) begin
      peer_ack <= 1'b0;
      rq1      <= 1'b0;
      rq2      <= 1'b0;
      pend     <= 1'b0;
      pcnt     <= 0;
    end else begin
      rq1 <= handshake_req;
      rq2 <= rq1;
      if (pend) begin
        if (pcnt == 0) begin
          peer_ack <= ~peer_ack;
          pend     <= 1'b0;
        end else begin
          pcnt <= pcnt - 1;
        end
      end else if (rq2 != peer_ack) begin
        rx_data.push_back(handshake_data);
        rx_tag.push_back(handshake_tag);
        pend <= 1'b1;
        pcnt <= int'($urandom_range(dly_hi, dly_lo));
      end
    end
  end

  // Source-side reference: round-robin prediction, expected word stream, stability
  logic [PORTS-1:0] acc_vec   = '0;
  int               model_last = PORTS - 1;
  logic [SIZE-1:0]  lat_data  = '0;
  logic [TAG_W-1:0] lat_tag   = '0;
  logic             prev_req  = 1'b0;
  int               toggles   = 0;
  logic [SIZE-1:0]  exp_data [$];
  logic [TAG_W-1:0] exp_tag  [$];

  always @(negedge clk) begin
    acc_vec <= in_valid & in_ready;
    if (!rst_n) begin
      model_last <= PORTS - 1;
      prev_req   <= 1'b0;
    end else begin
      if (busy) begin
        check("stable_data", 32'(handshake_data), 32'(lat_data));
        check("stable_tag", 32'(handshake_tag), 32'(lat_tag));
      end
      if (handshake_req != prev_req) toggles <= toggles + 1;
      prev_req <= handshake_req;
      if (in_ready != '0) begin
        check("rr_pick", 32'(in_ready), 32'(model_pick(in_valid, model_last)));
        for (int i = 0; i < PORTS; i++) begin
          if (in_ready[i] && in_valid[i]) begin
            exp_tag.push_back(TAG_W'(i));
            exp_data.push_back(word[i]);
            model_last <= i;
            lat_data   <= word[i];
            lat_tag    <= TAG_W'(i);
          end
        end
      end
    end
  end

  task automatic clear_queues();
    rx_data.delete();
    rx_tag.delete();
    exp_data.delete();
    exp_tag.delete();
  endtask

  task automatic do_reset(input logic hold_ack);
    in_valid  = '0;
    force_en  = hold_ack;
    force_val = hold_ack;
    rst_n     = 1'b0;
    peer_rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_queues();
    rst_n    = 1'b1;
    peer_rst = 1'b0;
  endtask

  task automatic run_traffic(input logic rr, input int target, input int max_cyc);
    int cyc;
    cyc = 0;
    while (exp_tag.size() < target && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < PORTS; i++) begin
        if (rr) begin
          word[i]     = SIZE'(8'h10 + i);
          in_valid[i] = (exp_tag.size() < target);
        end else if (acc_vec[i]) begin
          in_valid[i] = 1'b0;
        end else if (!in_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            word[i]     = SIZE'($urandom);
            in_valid[i] = 1'b1;
          end
        end else if ($urandom_range(50) == 0) begin
          in_valid[i] = 1'b0;
        end
      end
    end
    check("traffic_done", 32'(exp_tag.size() >= target), 32'd1);
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((rx_tag.size() != exp_tag.size() || busy) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc >= 5000), 32'd0);
    check({tag, "_count"}, 32'(rx_tag.size()), 32'(exp_tag.size()));
    for (int i = 0; i < exp_tag.size() && i < rx_tag.size(); i++) begin
      check({tag, "_tag"}, 32'(rx_tag[i]), 32'(exp_tag[i]));
      check({tag, "_data"}, 32'(rx_data[i]), 32'(exp_data[i]));
    end
  endtask

  initial begin
    int   n;
    int   t0;
    logic seen;
    in_valid = '0;
    for (int i = 0; i < PORTS; i++) word[i] = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(handshake_data), 32'd0);
    check("rst_tag", 32'(handshake_tag), 32'd0);
    check("rst_req", 32'(handshake_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    peer_rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (handshake_req || busy || in_ready != '0) seen = 1'b1;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // Single transfer from port 2
    dly_lo = 5;
    dly_hi = 5;
    @(posedge clk);
    #1;
    word[2]  = 8'hA5;
    in_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(in_ready), 32'h4);
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    check("single_data", 32'(handshake_data), 32'hA5);
    check("single_tag", 32'(handshake_tag), 32'd2);
    check("single_req_hold", 32'(handshake_req), 32'd0);
    check("single_ready_off", 32'(in_ready), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_req_toggle", 32'(handshake_req), 32'd1);
    n = 0;
    while (!handshake_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("single_ack_seen", 32'(handshake_ack), 32'd1);
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_window", 32'(n >= 2 && n <= 3), 32'd1);
    drain("single");
    if (rx_tag.size() > 0) begin
      check("single_rx_tag", 32'(rx_tag[0]), 32'd2);
      check("single_rx_data", 32'(rx_data[0]), 32'hA5);
    end

    // Round-robin with all ports valid
    do_reset(1'b0);
    dly_lo = 0;
    dly_hi = 15;
    t0 = toggles;
    run_traffic(1'b1, 6, 3000);
    drain("rr");
    check("rr_rx_count", 32'(rx_tag.size()), 32'd6);
    for (int k = 0; k < 6 && k < rx_tag.size(); k++) begin
      check("rr_order_tag", 32'(rx_tag[k]), 32'(k % 4));
      check("rr_order_data", 32'(rx_data[k]), 32'(8'h10 + k % 4));
    end
    check("rr_toggles", 32'(toggles - t0), 32'd6);

    // Random traffic, random peer latency
    do_reset(1'b0);
    t0 = toggles;
    run_traffic(1'b0, 1000, 60000);
    drain("rand");
    check("rand_toggles", 32'(toggles - t0), 32'(exp_tag.size()));

    // Peer holding ack high after reset stalls the arbiter
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    word[0]  = 8'h77;
    in_valid = 4'b0001;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready != '0) seen = 1'b1;
    end
    check("stall_no_ready", 32'(seen), 32'd0);
    check("stall_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    force_val = 1'b0;
    n = 0;
    while (in_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stall_grant_within_3", 32'(n <= 3 && in_ready == 4'b0001), 32'd1);
    @(posedge clk);
    #1;
    in_valid = '0;
    repeat (4) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_req", 32'(handshake_req), 32'd1);

    // Reset during WAIT, peer reset alongside
    @(posedge clk);
    #5;
    rst_n    = 1'b0;
    peer_rst = 1'b1;
    #1;
    check("midrst_req", 32'(handshake_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    force_en  = 1'b0;
    force_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_queues();
    rst_n    = 1'b1;
    peer_rst = 1'b0;
    word[1]  = 8'h5A;
    in_valid = 4'b0010;
    n = 0;
    while (in_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_grant", 32'(in_ready), 32'h2);
    @(posedge clk);
    #1;
    in_valid = '0;
    drain("post_rst");
    if (rx_tag.size() > 0) begin
      check("post_rst_tag", 32'(rx_tag[0]), 32'd1);
      check("post_rst_data", 32'(rx_data[0]), 32'h5A);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
